univ_shift_reg: RTL and testbench

Parametrised universal shift register: the edge-triggered, multi-mode successor to the basic D latch and D flip-flop storage cells. It holds a WIDTH-bit word and supports hold, shift left/right with serial inputs, rotate left/right, parallel load and clear. A shift counter raises a one-cycle `word_done` pulse each time a full word has been shifted, so the block can serve directly as a SIPO/PISO serial link endpoint.

---
 rtl/univ_shift_reg.sv | 97 +++++++++
 tb/tb_univ_shift_reg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, load and clear.
// A modulo-WIDTH shift counter pulses word_done once per completed word.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CW        = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic              sout_r,
    output logic              sout_l,
    output logic [CW-1:0]     cnt,
    output logic              word_done
);
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             advance;

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (mode)
            MODE_HOLD: data_d = data_q;
            MODE_SHR: begin
                data_d  = {sin_l, data_q[WIDTH-1:1]};
                advance = 1'b1;
            end
            MODE_SHL: begin
                data_d  = {data_q[WIDTH-2:0], sin_r};
                advance = 1'b1;
            end
            MODE_LOAD: begin
                data_d = d;
                cnt_d  = '0;
            end
            MODE_ROR: begin
                data_d  = {data_q[0], data_q[WIDTH-1:1]};
                advance = 1'b1;
            end
            MODE_ROL: begin
                data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                advance = 1'b1;
            end
            MODE_CLR: begin
                data_d = '0;
                cnt_d  = '0;
            end
            default: data_d = data_q;
        endcase

        // Wrap explicitly at WIDTH-1 so non-power-of-two widths count correctly.
        done_d = 1'b0;
        if (advance) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q         = data_q;
    assign cnt       = cnt_q;
    assign word_done = done_q;
    assign sout_r    = data_q[0];
    assign sout_l    = data_q[WIDTH-1];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic, checked by
// a scoreboard fed from an arithmetic reference model.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int CW = 3;
    localparam logic [W-1:0] RV = 8'hA5;
    localparam int EW = W + CW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_l, sin_r;
    logic [W-1:0]  q;
    logic          sout_r, sout_l;
    logic [CW-1:0] cnt;
    logic          word_done;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit stim_done = 1'b0;

    // Reference model state: plain integers.
    int m_q;
    int m_adv;
    int m_wd;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .word_done(word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, update the model at the edge, queue the result.
    task automatic step(input logic r, input logic [2:0] m, input logic [W-1:0] dd,
                        input logic sl, input logic sr);
        bit adv;
        rst = r; mode = m; d = dd; sin_l = sl; sin_r = sr;
        @(posedge clk);
        adv = 1'b0;
        if (r) begin
            m_q = int'(RV); m_adv = 0; m_wd = 0;
        end else begin
            case (m)
                3'd1: begin m_q = (m_q / 2) + (int'(sl) * 128); adv = 1; end
                3'd2: begin m_q = ((m_q * 2) % 256) + int'(sr); adv = 1; end
                3'd3: begin m_q = int'(dd); m_adv = 0; end
                3'd4: begin m_q = (m_q / 2) + ((m_q % 2) * 128); adv = 1; end
                3'd5: begin m_q = ((m_q * 2) % 256) + (m_q / 128); adv = 1; end
                3'd6: begin m_q = 0; m_adv = 0; end
                default: ;
            endcase
            if (adv) m_adv++;
            m_wd = (adv && (m_adv % W == 0)) ? 1 : 0;
        end
        exp_q.push_back({m_q[W-1:0], CW'(m_adv % W), m_wd[0]});
        #1;
    endtask

    // Monitor: every cycle the DUT presents a new state; compare against the queue.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q",         int'(q),         int'(e[EW-1:CW+1]));
                check("cnt",       int'(cnt),       int'(e[CW:1]));
                check("word_done", int'(word_done), int'(e[0]));
                check("sout_l",    int'(sout_l),    int'(e[EW-1]));
                check("sout_r",    int'(sout_r),    int'(e[CW+1]));
            end
        end
    end

    initial begin
        logic [7:0] pat;
        rst = 1'b1; mode = 3'b011; d = 8'hFF; sin_l = 0; sin_r = 0;
        m_q = 0; m_adv = 0; m_wd = 0;

        step(1, 3'b011, 8'hFF, 0, 0);                     // reset beats load
        step(0, 3'b011, 8'h81, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 3'b001, 8'h00, 0, 0);
        step(0, 3'b000, 8'h00, 0, 0);

        step(0, 3'b110, 8'h00, 0, 0);                      // SIPO
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) step(0, 3'b010, 8'h00, 0, pat[i]);
        for (int i = 0; i < 8; i++) step(0, 3'b010, 8'h00, 0, 1'($urandom_range(0, 1)));

        step(0, 3'b011, 8'h01, 0, 0);                      // rotate / reserved
        for (int i = 0; i < 3; i++) step(0, 3'b101, 8'h00, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 3'b111, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 3'b100, 8'h00, 0, 0);

        for (int i = 0; i < 7; i++) step(0, 3'b001, 8'h00, 1, 0);  // interrupted
        step(0, 3'b011, 8'h3C, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 3'b010, 8'h00, 0, 1);
        step(1, 3'b001, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 3'b001, 8'h00, 1, 1);
        step(1, 3'b001, 8'h00, 0, 0);                      // reset at wrap
        step(0, 3'b000, 8'h00, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 40) == 0), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++)                       // long mixed run
            step(0, 3'($urandom_range(1, 2) == 1 ? 3'b001 : 3'b101), 8'h00,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
